// File: rtl/lif_sweep_scheduler.sv
// rtl/lif_sweep_scheduler.sv - sweeps one shared LIF update unit across all neurons once per timestep
module lif_sweep_scheduler #(
  parameter int N_NEURONS = 8,
  parameter int IDX_W     = 3,
  parameter int DIV_W     = 23,
  parameter int I_W       = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ena,
  input  logic [DIV_W-1:0]         prescale,
  input  logic [N_NEURONS*I_W-1:0] cur_in,
  output logic                     upd_valid,
  input  logic                     upd_ready,
  output logic [IDX_W-1:0]         upd_idx,
  output logic [I_W-1:0]           upd_current,
  input  logic                     resp_valid,
  input  logic                     resp_spike,
  output logic [N_NEURONS-1:0]     spike_vec,
  output logic                     vec_valid,
  output logic                     busy,
  output logic                     overrun,
  input  logic                     ovr_clr
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_WAIT   = 2'd2,
    S_COMMIT = 2'd3
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);

  state_t               state;
  state_t               state_nxt;
  logic [DIV_W-1:0]     div_cnt;
  logic                 tick;
  logic [IDX_W-1:0]     idx;
  logic [IDX_W-1:0]     idx_inc;
  logic [N_NEURONS-1:0] shadow;
  logic [N_NEURONS-1:0] shadow_upd;
  logic [I_W-1:0]       cur_lat;
  logic                 start_sweep;
  logic                 accept_resp;

  // A compare hit only counts while enabled; a count already past a lowered
  // prescale simply runs on and wraps at 2^DIV_W.
  assign tick    = ena && (div_cnt == prescale);
  assign idx_inc = idx + IDX_W'(1);

  assign upd_idx     = idx;
  assign upd_current = cur_lat;

  // Timestep prescaler: counts enabled cycles, wraps to zero on every tick.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (ena) begin
      div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
    end
  end

  // Sweep state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake outputs; a response is only taken in WAIT, so one
  // arriving in the handshake cycle or while idle falls on the floor.
  always_comb begin
    state_nxt   = state;
    upd_valid   = 1'b0;
    vec_valid   = 1'b0;
    busy        = (state != S_IDLE);
    start_sweep = 1'b0;
    accept_resp = 1'b0;
    case (state)
      S_IDLE: begin
        if (tick) begin
          start_sweep = 1'b1;
          state_nxt   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        upd_valid = 1'b1;
        if (upd_ready) begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (resp_valid) begin
          accept_resp = 1'b1;
          state_nxt   = (idx == LAST_IDX) ? S_COMMIT : S_ISSUE;
        end
      end
      S_COMMIT: begin
        vec_valid = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Shadow vector with the incoming spike merged at the outstanding index.
  always_comb begin
    shadow_upd      = shadow;
    shadow_upd[idx] = resp_spike;
  end

  // Sweep datapath. The vector is published on the edge into COMMIT so that
  // spike_vec already carries the new timestep while vec_valid pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx       <= '0;
      shadow    <= '0;
      cur_lat   <= '0;
      spike_vec <= '0;
    end else if (start_sweep) begin
      idx     <= '0;
      shadow  <= '0;
      cur_lat <= cur_in[0 +: I_W];
    end else if (accept_resp) begin
      shadow <= shadow_upd;
      if (idx == LAST_IDX) begin
        spike_vec <= shadow_upd;
      end else begin
        idx     <= idx_inc;
        cur_lat <= cur_in[idx_inc*I_W +: I_W];
      end
    end
  end

  // Sticky overrun: a tick landing on any non-idle cycle, COMMIT included.
  // Setting takes priority over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (tick && busy) begin
      overrun <= 1'b1;
    end else if (ovr_clr) begin
      overrun <= 1'b0;
    end
  end

endmodule
